// File: rtl/fir_coeff_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// fir_coeff_bank_ctrl_if
// Groups the coefficient-write port, the commit request and the outputs of
// the FIR coefficient bank controller.
//   iCoeffWrValid  shadow-bank write request
//   oCoeffWrReady  write accepted when valid & ready
//   iCoeffWrAddr   tap index
//   iCoeffWrData   signed coefficient value
//   iCommit        shadow->active swap request (1-cycle pulse)
//   oEnSample_300k 1-cycle sample strobe shared by all FIR segments
//   oCoeffAll      active bank, tap k at [k*COEFF_W +: COEFF_W]
//   oCommitDone    1-cycle pulse on the cycle after the swap edge
//   oWrErr         1-cycle pulse on a write to an out-of-range tap
//   oBusy          high while a commit is pending
// Modports: slave = controller side, master = software/driver side.
// ---------------------------------------------------------------------------
interface fir_coeff_bank_ctrl_if #(
  parameter int NUM_TAPS = 12,
  parameter int COEFF_W  = 16
);
  localparam int ADDR_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  logic                         iCoeffWrValid;
  logic                         oCoeffWrReady;
  logic [ADDR_W-1:0]            iCoeffWrAddr;
  logic signed [COEFF_W-1:0]    iCoeffWrData;
  logic                         iCommit;
  logic                         oEnSample_300k;
  logic [NUM_TAPS*COEFF_W-1:0]  oCoeffAll;
  logic                         oCommitDone;
  logic                         oWrErr;
  logic                         oBusy;

  modport slave (
    input  iCoeffWrValid, iCoeffWrAddr, iCoeffWrData, iCommit,
    output oCoeffWrReady, oEnSample_300k, oCoeffAll, oCommitDone, oWrErr, oBusy
  );

  modport master (
    output iCoeffWrValid, iCoeffWrAddr, iCoeffWrData, iCommit,
    input  oCoeffWrReady, oEnSample_300k, oCoeffAll, oCommitDone, oWrErr, oBusy
  );
endinterface

// File: rtl/fir_coeff_bank_ctrl.sv
// ---------------------------------------------------------------------------
// fir_coeff_bank_ctrl
// Upstream control stage for the transposed FIR segments. Divides the system
// clock down to a one-cycle sample strobe every DIV clocks and keeps a
// double-buffered coefficient bank: writes land in the shadow bank, and a
// commit copies shadow to active on a sample boundary so no output sample
// ever mixes old and new coefficients.
// Ports:
//   iClk_12M  system clock
//   iRst      asynchronous reset, active-high
//   bus       fir_coeff_bank_ctrl_if.slave (write port, commit, strobe,
//             active bank and status pulses)
// ---------------------------------------------------------------------------
module fir_coeff_bank_ctrl #(
  parameter int NUM_TAPS = 12,
  parameter int COEFF_W  = 16,
  parameter int DIV      = 40
) (
  input  logic                  iClk_12M,
  input  logic                  iRst,
  fir_coeff_bank_ctrl_if.slave  bus
);

  localparam int ADDR_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int CNT_W  = $clog2(DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DIV - 1);
  // One extra bit so the bound still compares correctly when NUM_TAPS is a power of two.
  localparam logic [ADDR_W:0]   NUM_TAPS_L = (ADDR_W + 1)'(NUM_TAPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic                                strobe_q, strobe_d;
  logic [NUM_TAPS-1:0][COEFF_W-1:0]    shadow_q, shadow_d;
  logic [NUM_TAPS-1:0][COEFF_W-1:0]    active_q, active_d;
  logic                                ready_q, ready_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                wr_err_q, wr_err_d;

  logic                                wr_fire_s;
  logic                                addr_ok_s;
  logic                                cnt_wrap_s;

  assign wr_fire_s  = bus.iCoeffWrValid & ready_q;
  assign addr_ok_s  = ({1'b0, bus.iCoeffWrAddr} < NUM_TAPS_L);
  assign cnt_wrap_s = (cnt_q == CNT_MAX);

  // Sample divider: count 0..DIV-1; the strobe flop rises on the edge that wraps the count.
  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = cnt_wrap_s;
    if (cnt_wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Bank/commit next-state logic; status outputs are computed here and registered below.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        // A write in the same cycle as a commit lands before the swap is armed.
        if (wr_fire_s) begin
          if (addr_ok_s) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
              if (bus.iCoeffWrAddr == ADDR_W'(k)) begin
                shadow_d[k] = bus.iCoeffWrData;
              end else begin
                shadow_d[k] = shadow_q[k];
              end
            end
          end else begin
            wr_err_d = 1'b1;
          end
        end else begin
          wr_err_d = 1'b0;
        end
        if (bus.iCommit) begin
          state_d = ST_PEND;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        // Swap on the strobe edge itself: segments sampling on this edge still see the old bank.
        if (strobe_q) begin
          active_d = shadow_q;
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, banks, divider and registered outputs; reset aborts any pending commit.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.oCoeffWrReady  = ready_q;
  assign bus.oEnSample_300k = strobe_q;
  assign bus.oCoeffAll      = active_q;
  assign bus.oCommitDone    = done_q;
  assign bus.oWrErr         = wr_err_q;
  assign bus.oBusy          = busy_q;

endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_bank_ctrl
// Directed bench for fir_coeff_bank_ctrl: divider timing, write/commit table,
// commit on a strobe cycle, same-cycle write+commit, reset during a commit.
// ---------------------------------------------------------------------------
module tb_fir_coeff_bank_ctrl;
  localparam int NUM_TAPS = 12;
  localparam int COEFF_W  = 16;
  localparam int DIV      = 40;
  localparam int ALL_W    = NUM_TAPS * COEFF_W;

  typedef struct {
    logic        valid;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        commit;
    logic        exp_ready;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;

  logic clk;
  logic rst;
  int   edge_n;
  int   n_checks;
  int   n_fail;

  vec_t             vecs [16];
  logic [ALL_W-1:0] bank0, bank1, bank2, bank3;

  fir_coeff_bank_ctrl_if #(.NUM_TAPS(NUM_TAPS), .COEFF_W(COEFF_W)) bus ();

  fir_coeff_bank_ctrl #(.NUM_TAPS(NUM_TAPS), .COEFF_W(COEFF_W), .DIV(DIV)) dut (
    .iClk_12M (clk),
    .iRst     (rst),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; edge 1 is the first rising edge with rst low.
  always @(posedge clk) edge_n <= rst ? 0 : edge_n + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %b expected %b", name, edge_n, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [ALL_W-1:0] act, input logic [ALL_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic check_tap(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  // Advance to a target edge while a state is expected to hold steady; bounded.
  task automatic run_to(input int target, input logic exp_busy, input logic [ALL_W-1:0] exp_bank);
    int guard;
    guard = 0;
    while (edge_n < target && guard < 2000) begin
      tick();
      guard++;
      check_bit("busy_hold", bus.oBusy, exp_busy);
      check_bit("done_quiet", bus.oCommitDone, 1'b0);
      check_vec("bank_hold", bus.oCoeffAll, exp_bank);
    end
    n_checks++;
    if (edge_n != target) begin
      n_fail++;
      $display("FAIL run_to: reached edge %0d expected %0d", edge_n, target);
    end
  endtask

  task automatic clear_inputs();
    bus.iCoeffWrValid = 1'b0;
    bus.iCoeffWrAddr  = 4'd0;
    bus.iCoeffWrData  = 16'sd0;
    bus.iCommit       = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_inputs();

    // Expected banks.
    bank0 = '0;
    for (int k = 0; k < NUM_TAPS; k++) bank1[k*COEFF_W +: COEFF_W] = 16'(100 + k);
    bank2 = bank1;
    bank2[0*COEFF_W +: COEFF_W] = 16'd500;
    bank3 = bank2;
    bank3[5*COEFF_W +: COEFF_W] = 16'hFFFF;

    // Write/commit vector table: taps 0..11, bad address, idle, commit, write while pending.
    for (int i = 0; i < 12; i++)
      vecs[i] = '{1'b1, 4'(i), 16'(100 + i), 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 4'd12, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 4'd2,  16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_ready", bus.oCoeffWrReady, 1'b0);
    check_bit("rst_strobe", bus.oEnSample_300k, 1'b0);
    check_bit("rst_busy", bus.oBusy, 1'b0);
    check_bit("rst_done", bus.oCommitDone, 1'b0);
    check_bit("rst_err", bus.oWrErr, 1'b0);
    check_vec("rst_bank", bus.oCoeffAll, bank0);
    rst = 1'b0;

    // Divider: strobe after edges 40, 80, 120 only.
    for (int i = 0; i < 120; i++) begin
      tick();
      check_bit("strobe", bus.oEnSample_300k, (edge_n % DIV) == 0);
      check_bit("ready_idle", bus.oCoeffWrReady, 1'b1);
    end

    // Table: writes, bad address, commit mid-period, write while pending.
    for (int i = 0; i < 16; i++) begin
      bus.iCoeffWrValid = vecs[i].valid;
      bus.iCoeffWrAddr  = vecs[i].addr;
      bus.iCoeffWrData  = vecs[i].data;
      bus.iCommit       = vecs[i].commit;
      tick();
      check_bit("tbl_ready", bus.oCoeffWrReady, vecs[i].exp_ready);
      check_bit("tbl_err", bus.oWrErr, vecs[i].exp_err);
      check_bit("tbl_busy", bus.oBusy, vecs[i].exp_busy);
    end
    clear_inputs();

    // Pending until the strobe; the strobe-edge sample still sees the old bank.
    run_to(160, 1'b1, bank0);
    check_bit("strobe160", bus.oEnSample_300k, 1'b1);
    tick();
    check_vec("swap1_bank", bus.oCoeffAll, bank1);
    check_bit("swap1_done", bus.oCommitDone, 1'b1);
    check_bit("swap1_busy", bus.oBusy, 1'b0);
    check_bit("swap1_ready", bus.oCoeffWrReady, 1'b0);
    tick();
    check_bit("post1_done", bus.oCommitDone, 1'b0);
    check_bit("post1_ready", bus.oCoeffWrReady, 1'b1);

    // Commit on a strobe cycle: swap waits a full period.
    bus.iCoeffWrValid = 1'b1;
    bus.iCoeffWrAddr  = 4'd0;
    bus.iCoeffWrData  = 16'sd500;
    tick();
    clear_inputs();
    run_to(200, 1'b0, bank1);
    check_bit("strobe200", bus.oEnSample_300k, 1'b1);
    bus.iCommit = 1'b1;
    tick();
    clear_inputs();
    check_bit("c2_busy", bus.oBusy, 1'b1);
    check_vec("c2_noswap", bus.oCoeffAll, bank1);
    run_to(240, 1'b1, bank1);
    tick();
    check_vec("swap2_bank", bus.oCoeffAll, bank2);
    check_bit("swap2_done", bus.oCommitDone, 1'b1);
    tick();

    // Same-cycle write of -1 to tap 5 plus commit.
    bus.iCoeffWrValid = 1'b1;
    bus.iCoeffWrAddr  = 4'd5;
    bus.iCoeffWrData  = -16'sd1;
    bus.iCommit       = 1'b1;
    tick();
    clear_inputs();
    check_bit("c3_busy", bus.oBusy, 1'b1);
    check_bit("c3_ready", bus.oCoeffWrReady, 1'b0);
    run_to(280, 1'b1, bank2);
    tick();
    check_vec("swap3_bank", bus.oCoeffAll, bank3);
    check_tap("swap3_tap5", bus.oCoeffAll[5*COEFF_W +: COEFF_W], 16'hFFFF);
    check_bit("swap3_done", bus.oCommitDone, 1'b1);
    tick();

    // Reset while pending: commit aborted, banks cleared, divider restarts.
    bus.iCoeffWrValid = 1'b1;
    bus.iCoeffWrAddr  = 4'd3;
    bus.iCoeffWrData  = 16'sh0AAA;
    bus.iCommit       = 1'b1;
    tick();
    clear_inputs();
    check_bit("c4_busy", bus.oBusy, 1'b1);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check_vec("arst_bank", bus.oCoeffAll, bank0);
    check_bit("arst_busy", bus.oBusy, 1'b0);
    check_bit("arst_ready", bus.oCoeffWrReady, 1'b0);
    check_bit("arst_done", bus.oCommitDone, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      check_bit("r_strobe", bus.oEnSample_300k, edge_n == DIV);
      check_bit("r_done", bus.oCommitDone, 1'b0);
      check_bit("r_busy", bus.oBusy, 1'b0);
      check_bit("r_ready", bus.oCoeffWrReady, 1'b1);
      check_vec("r_bank", bus.oCoeffAll, bank0);
    end

    // Commit with no writes: shadow was cleared, so active stays zero.
    bus.iCommit = 1'b1;
    tick();
    clear_inputs();
    check_bit("c5_busy", bus.oBusy, 1'b1);
    run_to(80, 1'b1, bank0);
    tick();
    check_bit("swap5_done", bus.oCommitDone, 1'b1);
    check_vec("swap5_bank", bus.oCoeffAll, bank0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
